// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit: shift-add multiply, restoring divide.
// Results land in Hi/Lo; Done pulses one cycle when they are valid.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic             Sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_n;

  // acc holds the product, or {rem, quo} while dividing
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   bmag;
  logic [CNT_W-1:0]   cnt;
  logic               op_q;
  logic               neg_p;
  logic               neg_r;
  logic               dz;

  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mult_nxt;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   quo_sh;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH-1:0] div_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    a_neg  = Sign & A[WIDTH-1];
    b_neg  = Sign & B[WIDTH-1];
    a_mag  = a_neg ? -A : A;
    b_mag  = b_neg ? -B : B;
    b_zero = (B == '0);
  end

  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, bmag} : {(WIDTH+1){1'b0}});
    mult_nxt = {add_sum, acc[WIDTH-1:1]};
  end

  // rem < divisor always holds, so a set rem_sh MSB means the subtract fits
  always_comb begin
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    quo_sh = {acc[WIDTH-2:0], 1'b0};
    trial  = {1'b0, rem_sh} - {2'b00, bmag};
    if (trial[WIDTH+1])
      div_nxt = {rem_sh[WIDTH-1:0], quo_sh};
    else
      div_nxt = {trial[WIDTH-1:0], quo_sh[WIDTH-1:1], 1'b1};
  end

  always_comb begin
    prod_fix = neg_p ? -acc : acc;
    quo_fix  = neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (Start) begin
          if (!Op)        state_n = S_MULT;
          else if (b_zero) state_n = S_DONE;
          else            state_n = S_DIV;
        end
      end
      S_MULT: if (cnt == CNT_W'(1)) state_n = S_FIX;
      S_DIV:  if (cnt == CNT_W'(1)) state_n = S_FIX;
      S_FIX:  state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc   <= '0;
      bmag  <= '0;
      cnt   <= '0;
      op_q  <= 1'b0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      Hi    <= '0;
      Lo    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            op_q  <= Op;
            acc   <= {{WIDTH{1'b0}}, a_mag};
            bmag  <= b_mag;
            cnt   <= CNT_W'(WIDTH);
            neg_p <= a_neg ^ b_neg;
            neg_r <= a_neg;
            dz    <= Op & b_zero;
          end
        end
        S_MULT: begin
          acc <= mult_nxt;
          cnt <= cnt - CNT_W'(1);
        end
        S_DIV: begin
          acc <= div_nxt;
          cnt <= cnt - CNT_W'(1);
        end
        S_FIX: begin
          if (op_q) begin
            Hi <= rem_fix;
            Lo <= quo_fix;
          end else begin
            Hi <= prod_fix[2*WIDTH-1:WIDTH];
            Lo <= prod_fix[WIDTH-1:0];
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

  always_comb begin
    Busy    = (state == S_MULT) || (state == S_DIV) || (state == S_FIX);
    Done    = (state == S_DONE);
    DivZero = (state == S_DONE) & dz;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: random and directed ops vs.
// a plain-arithmetic reference model; plus a WIDTH=8 instance.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset, Start, Op, Sign;
  logic [W-1:0] A, B, Hi, Lo;
  logic         Busy, Done, DivZero;

  logic         Start8, Op8, Sign8;
  logic [7:0]   A8, B8, Hi8, Lo8;
  logic         Busy8, Done8, DivZero8;

  always #5 Clk = ~Clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .Sign(Sign),
    .A(A), .B(B), .Hi(Hi), .Lo(Lo),
    .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .Start(Start8), .Op(Op8), .Sign(Sign8),
    .A(A8), .B(B8), .Hi(Hi8), .Lo(Lo8),
    .Busy(Busy8), .Done(Done8), .DivZero(DivZero8)
  );

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           at;
    int           busy;
  } exp_t;

  exp_t         sbq[$];
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference: 64-bit arithmetic on sign- or zero-extended operands
  function automatic void model(input logic op, input logic sign,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi,
                                output logic [W-1:0] lo,
                                output logic dz);
    logic [63:0] pa, pb, p;
    longint      sa, sb, q, r;
    pa = sign ? {{32{a[W-1]}}, a} : {32'h0, a};
    pb = sign ? {{32{b[W-1]}}, b} : {32'h0, b};
    sa = longint'(pa);
    sb = longint'(pb);
    dz = 1'b0;
    if (!op) begin
      p  = pa * pb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == '0) begin
      dz = 1'b1;
      hi = m_hi;
      lo = m_lo;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  int busy_run = 0;
  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got Done=1 at cycle %0d, required no pending op", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("hi", Hi, e.hi);
        check("lo", Lo, e.lo);
        check("divzero", DivZero, e.dz);
        check("done_cycle", cyc, e.at);
        check("busy_cycles", busy_run, e.busy);
        check("busy_at_done", Busy, 0);
      end
    end
    busy_run = (Busy === 1'b1) ? busy_run + 1 : 0;
  end

  task automatic issue(input logic op, input logic sign,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W-1:0] h, l;
    logic         d;
    @(posedge Clk);
    #1;
    Op = op; Sign = sign; A = a; B = b; Start = 1'b1;
    model(op, sign, a, b, h, l, d);
    m_hi = h;
    m_lo = l;
    e.hi = h; e.lo = l; e.dz = d;
    e.at   = d ? cyc + 1 : cyc + W + 2;
    e.busy = d ? 0 : W + 1;
    sbq.push_back(e);
    @(posedge Clk);
    #1;
    Start = 1'b0;
    Op = 1'($urandom); Sign = 1'($urandom);
    A = $urandom; B = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge Clk);
      n++;
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d pending ops, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic run8(input logic op, input logic sign,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eh, input logic [7:0] el);
    int c0;
    int n = 0;
    @(posedge Clk);
    #1;
    Op8 = op; Sign8 = sign; A8 = a; B8 = b; Start8 = 1'b1;
    c0 = cyc;
    @(posedge Clk);
    #1;
    Start8 = 1'b0;
    @(negedge Clk);
    while (Done8 !== 1'b1 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check("w8_done_seen", Done8, 1);
    check("w8_done_cycle", cyc, c0 + 10);
    check("w8_hi", Hi8, eh);
    check("w8_lo", Lo8, el);
  endtask

  function automatic logic [W-1:0] pick(input bit allow_zero);
    int s;
    s = $urandom_range(0, 9);
    case (s)
      0: return allow_zero ? '0 : 32'h1;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    Reset = 1'b1; Start = 1'b0; Op = 1'b0; Sign = 1'b0; A = '0; B = '0;
    Start8 = 1'b0; Op8 = 1'b0; Sign8 = 1'b0; A8 = '0; B8 = '0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_hi", Hi, 0);
    check("rst_lo", Lo, 0);
    check("rst_divzero", DivZero, 0);

    issue(1'b0, 1'b1, 32'h7, 32'hFFFF_FFFD);
    drain();
    issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h2);
    drain();
    issue(1'b1, 1'b0, 32'd100, 32'd7);
    drain();
    issue(1'b1, 1'b1, 32'h5, 32'h0);
    drain();
    issue(1'b0, 1'b0, 32'h1234, 32'h10);
    drain();

    issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (3) @(posedge Clk);
    #1;
    Start = 1'b1; Op = 1'b0; Sign = 1'b0; A = 32'h55; B = 32'h3;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    drain();

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("hold_hi", Hi, m_hi);
    check("hold_lo", Lo, m_lo);

    issue(1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    sbq.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge Clk);
    check("midrst_busy", Busy, 0);
    check("midrst_done", Done, 0);
    check("midrst_hi", Hi, 0);
    check("midrst_lo", Lo, 0);
    issue(1'b0, 1'b1, 32'h7, 32'hFFFF_FFFD);
    drain();

    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), 1'($urandom), pick(1'b1), pick(1'b1));
      drain();
    end

    run8(1'b0, 1'b1, 8'h81, 8'h02, 8'hFF, 8'h02);
    run8(1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01);
    run8(1'b1, 1'b1, 8'hF9, 8'h02, 8'hFF, 8'hFD);

    repeat (5) @(posedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
